// File: rtl/module_debounce_sw_bt_pkg.sv
// Shared constants for the switch/button debounce stage.
// The defaults describe the board configuration; benches override them through parameters.
package pkg_sw_bt;

   localparam int SW_BT_WIDTH      = 20;
   localparam int DEB_TICK_DIV     = 100000;
   localparam int DEB_STABLE_TICKS = 10;

   // Counter width large enough to hold 0..stable_ticks.
   function automatic int cnt_width(input int stable_ticks);
      return $clog2(stable_ticks + 1);
   endfunction

   localparam int DEB_CNT_W = cnt_width(DEB_STABLE_TICKS);

endpackage

// File: rtl/module_debounce_sw_bt_bit.sv
// One debounced input: two-flop synchroniser, tick-qualified stability counter,
// debounced level register and registered rise/fall pulses.
module module_debounce_bit
   import pkg_sw_bt::*;
#(
   parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   input  logic tick_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int                CNT_W    = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      s1_d   = raw_i;
      s2_d   = s1_q;
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      // Any cycle back at the accepted level throws away partial qualification.
      if (s2_q == db_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_LAST) begin
            db_d   = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/module_debounce_sw_bt.sv
// Input conditioning for the switches/buttons peripheral: a shared sample-tick
// prescaler feeding one synchronise-and-debounce slice per pin.
module module_debounce_sw_bt
   import pkg_sw_bt::*;
#(
   parameter int WIDTH        = SW_BT_WIDTH,
   parameter int TICK_DIV     = DEB_TICK_DIV,
   parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] db_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   localparam int                 TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick;

   // Free-running: input activity never disturbs the sample phase.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      module_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .raw_i  (raw_i[g]),
         .tick_i (tick),
         .db_o   (db_o[g]),
         .rise_o (rise_o[g]),
         .fall_o (fall_o[g])
      );
   end

endmodule

// File: tb/tb_module_debounce_sw_bt.sv
// Bench for module_debounce_sw_bt with a small tick divider: a run-length model of the
// debounce rule is checked every cycle, alongside directed scenario checks.
module tb_module_debounce_sw_bt;

   localparam int W = 20;
   localparam int D = 4;
   localparam int S = 3;

   // ---------------- clock / reset ----------------
   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] raw   = '0;
   logic [W-1:0] db_o, rise_o, fall_o;

   always #5 clk = ~clk;

   module_debounce_sw_bt #(
      .WIDTH        (W),
      .TICK_DIV     (D),
      .STABLE_TICKS (S)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .raw_i  (raw),
      .db_o   (db_o),
      .rise_o (rise_o),
      .fall_o (fall_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      checks++;
      if (val < lo || val > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
      end
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   // A level is accepted once the synchronised pin has disagreed with the accepted
   // level for an unbroken run of cycles that contains S sample ticks. Ticks fall
   // on cycle indices c (counted from reset release) with (c+1) % D == 0.
   logic [3*W-1:0] exp_q[$];
   logic [3*W-1:0] exp_v;
   logic [W-1:0]   m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0;
   int             m_n = 0;
   int             run_len[W];
   int             run_start, n_ticks;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
         m_n  = 0;
         for (int i = 0; i < W; i++) run_len[i] = 0;
      end else begin
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (m_s2[i] != m_db[i]) begin
               run_len[i] = run_len[i] + 1;
               run_start  = m_n - run_len[i] + 1;
               n_ticks    = (m_n + 1) / D - run_start / D;
               if (n_ticks >= S) begin
                  m_db[i]    = m_s2[i];
                  m_rise[i]  = m_s2[i];
                  m_fall[i]  = ~m_s2[i];
                  run_len[i] = 0;
               end
            end else begin
               run_len[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw;
         m_n  = m_n + 1;
      end
      exp_q.push_back({m_db, m_rise, m_fall});
   end

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         check("cycle_db_rise_fall", {4'b0, db_o, rise_o, fall_o}, {4'b0, exp_v});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_db(input int idx, input logic lvl, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while ((db_o[idx] !== lvl) && (lat < 40));
   endtask

   // Returns at a negedge where the next posedge has cycle index == ph (mod D).
   task automatic align(input int ph);
      for (int k = 0; k < 2 * D && (m_n % D) != ph; k++) @(negedge clk);
   endtask

   int   lat;
   logic seen;
   logic found;

   initial begin
      // reset held with all pins high
      rst_n = 1'b0;
      raw   = 20'hFFFFF;
      repeat (3) begin
         @(negedge clk);
         check("reset_db", db_o, '0);
         check("reset_pulses", {rise_o, fall_o}, '0);
      end
      rst_n = 1'b1;
      raw   = '0;
      @(negedge clk);
      check("post_release_db", db_o, '0);
      check("post_release_pulses", {rise_o, fall_o}, '0);
      repeat (6) @(negedge clk);

      // clean rise on bit 0
      raw[0] = 1'b1;
      wait_db(0, 1'b1, lat);
      check_range("clean_rise_latency", lat, 11, 14);
      check("clean_rise_db", db_o, 20'h00001);
      check("clean_rise_pulse", rise_o, 20'h00001);
      @(negedge clk);
      check("clean_rise_pulse_width", rise_o, '0);

      // bounce on bit 5 never qualifies
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         raw[5] = (k % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            seen = seen | db_o[5] | rise_o[5];
         end
      end
      raw[5] = 1'b0;
      repeat (16) begin
         @(negedge clk);
         seen = seen | db_o[5] | rise_o[5];
      end
      check("bounce_rejected", seen, 1'b0);

      // late one-cycle dropout on bit 3 restarts qualification
      align(2);
      raw[3] = 1'b1;
      seen   = 1'b0;
      repeat (9) begin
         @(negedge clk);
         seen = seen | db_o[3];
      end
      raw[3] = 1'b0;
      @(negedge clk);
      seen = seen | db_o[3];
      raw[3] = 1'b1;
      wait_db(3, 1'b1, lat);
      check("late_bounce_no_early_db", seen, 1'b0);
      check_range("late_bounce_latency", lat, 11, 14);

      // two bits high, then released together
      raw = 20'h00003;
      repeat (20) @(negedge clk);
      check("multi_high_db", db_o, 20'h00003);
      raw   = '0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (fall_o != '0) found = 1'b1;
      end
      check("multi_fall_seen", found, 1'b1);
      check("multi_fall_pulse", fall_o, 20'h00003);
      check("multi_fall_db", db_o, '0);
      check("multi_fall_no_rise", rise_o, '0);
      @(negedge clk);
      check("multi_fall_width", fall_o, '0);

      // reset lands just before bit 7 would be accepted
      align(1);
      raw[7] = 1'b1;
      repeat (9) @(negedge clk);
      check("pre_reset_db7", db_o[7], 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_reset_db", db_o, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_reset_release_db", db_o, '0);
      wait_db(7, 1'b1, lat);
      check_range("requalify_latency", lat + 1, 11, 14);
      check("requalify_pulse", rise_o, 20'h00080);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
